hi_lo_muldiv_unit: RTL and testbench
====================================

// Module: hi_lo_muldiv_unit
// PURPOSE
//  Parametrised HI/LO unit for the MIPS datapath: holds HI/LO and computes MULT/MULTU/DIV/DIVU/MADD/MSUB
//  iteratively (one bit per cycle), plus single-cycle MTHI/MTLO. Sits beside the ALU in EX; the hazard
//  unit stalls MFHI/MFLO and new HI/LO ops while Busy=1. Results commit to HI/LO atomically on completion.
// PARAMETERS
//  WIDTH    32  operand and HI/LO register width (>=4)
//  CNT_W    $clog2(WIDTH)+1  iteration counter width (derived; do not override)
// PORTS
//  Clk        in   1      clock; all state updates on rising edge
//  Reset_n    in   1      asynchronous, active-low reset
//  Start      in   1      request; accepted only on an edge where Start=1 and Busy=0
//  Op         in   3      000 MULT,001 MULTU,010 DIV,011 DIVU,100 MTHI,101 MTLO,110 MADD,111 MSUB
//  A          in   WIDTH  rs operand (multiplicand/dividend/MTHI-MTLO data)
//  B          in   WIDTH  rt operand (multiplier/divisor)
//  Flush      in   1      synchronous cancel of in-flight op (branch/exception squash)
//  Busy       out  1      iterative op in progress
//  Done       out  1      one-cycle pulse: HI/LO updated on the preceding edge
//  Hi         out  WIDTH  HI register (registered value)
//  Lo         out  WIDTH  LO register (registered value)
// BEHAVIOUR
//  - Reset (Reset_n=0, any time, incl. mid-op): Hi=0, Lo=0, Busy=0, Done=0, FSM=IDLE, counter=0,
//    all partial-result regs cleared. Release takes effect at next edge.
//  - FSM: IDLE -> MUL (Op 000/001/110/111) or DIV (010/011) on accept; MUL/DIV -> IDLE after WIDTH
//    iterations or on Flush. MTHI/MTLO never leave IDLE.
//  - Accept edge E0: latch op; signed ops latch |A|,|B| and result sign(s); counter=0; Busy=1 after E0.
//  - Iterations on edges E1..E_WIDTH: MUL shift-add one multiplier bit; DIV restoring step one quotient
//    bit. At E_WIDTH: apply sign fix, write Hi/Lo, Busy=0, Done=1 for the following cycle only.
//    Result visible WIDTH cycles after accept; Hi/Lo hold old values throughout.
//  - MULT/MULTU: {Hi,Lo} = 2*WIDTH-bit signed/unsigned product.
//  - MADD/MSUB: {Hi,Lo} = {Hi,Lo} +/- signed product, mod 2^(2*WIDTH); uses {Hi,Lo} as at commit edge.
//  - DIV/DIVU: Lo=quotient (truncate toward zero), Hi=remainder (sign of dividend).
//  - Divide by zero: Lo=all ones, Hi=A (dividend), normal WIDTH-cycle latency, Done pulses.
//  - DIV overflow (A=MIN_INT, B=-1): Lo=MIN_INT, Hi=0.
//  - MTHI/MTLO: on accept edge write Hi (resp. Lo) = A; Busy stays 0; Done=1 next cycle.
//  - Start while Busy=1: ignored, no side effects. Requester must hold until accepted.
//  - Flush while Busy=1: at that edge FSM->IDLE, Busy=0, no commit, no Done; Hi/Lo unchanged.
//    Flush and Start on same edge with Busy=0: Start accepted (Flush only kills in-flight ops).
//    Flush on the commit edge E_WIDTH: Flush wins, no commit.
//  - Done and Start same cycle: Busy=0 so new Start is accepted that edge.
// TESTING
//  1 MULT A=0xFFFFFFFE B=3 -> after 32 cycles Hi=0xFFFFFFFF Lo=0xFFFFFFFA, Done 1 cycle, Busy 32 cycles.
//  2 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Hi=0xFFFFFFFE Lo=0x00000001; then MADD A=1 B=1 -> Lo=0x00000002.
//  3 DIVU 100/7 -> Lo=14 Hi=2; DIV -7/2 -> Lo=0xFFFFFFFD Hi=0xFFFFFFFF; DIV 0x80000000/-1 -> Lo=0x80000000 Hi=0.
//  4 DIV A=5 B=0 -> Lo=0xFFFFFFFF Hi=5; MTHI A=0x1234 -> Hi=0x1234 next cycle, Busy never high.
//  5 Start DIVU mid-MULT -> ignored, MULT result unchanged; Flush at iteration 10 -> no Done, Hi/Lo old.
//  6 Reset_n low asynchronously at iteration 5 (between edges) -> Hi/Lo/Busy/Done 0 immediately; next op exact.

Source files
------------

// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO unit for the MIPS EX stage: iterative multiply/divide (one bit per cycle),
// MADD/MSUB accumulate into {Hi,Lo}, and single-cycle MTHI/MTLO writes.
module hi_lo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic               signed_op, a_neg, b_neg, last_iter;
  logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod, hilo, mul_res;

  // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV;
  // opb holds |multiplicand| or |divisor| respectively.
  always_comb begin
    signed_op = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    a_neg     = signed_op & A[WIDTH-1];
    b_neg     = signed_op & B[WIDTH-1];
    a_abs     = a_neg ? -A : A;
    b_abs     = b_neg ? -B : B;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_step  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod = neg_q ? -mul_step : mul_step;
    hilo = {hi_q, lo_q};
    case (op_q)
      OP_MADD: mul_res = hilo + prod;
      OP_MSUB: mul_res = hilo - prod;
      default: mul_res = prod;
    endcase

    quo       = div_step[WIDTH-1:0];
    rem       = div_step[2*WIDTH-1:WIDTH];
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d  = Op;
          cnt_d = '0;
          case (Op)
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d   = S_DIV;
              acc_d     = {{WIDTH{1'b0}}, a_abs};
              opb_d     = b_abs;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              a_raw_d   = A;
              div0_d    = (B == '0);
            end
            default: begin
              state_d   = S_MUL;
              acc_d     = {{WIDTH{1'b0}}, b_abs};
              opb_d     = a_abs;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = 1'b0;
              div0_d    = 1'b0;
            end
          endcase
        end
      end
      S_MUL, S_DIV: begin
        // Flush beats the commit even on the final iteration edge.
        if (Flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_step : div_step;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            if (state_q == S_MUL) begin
              {hi_d, lo_d} = mul_res;
            end else if (div0_q) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              lo_d = neg_q ? -quo : quo;
              hi_d = rem_neg_q ? -rem : rem;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Directed bench for hi_lo_muldiv_unit (WIDTH=32): arithmetic results, latency,
// Busy/Done timing, ignored Start, Flush, and asynchronous reset.
module tb_hi_lo_muldiv_unit;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad   = 0;

  hi_lo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  // Issues one op from idle and waits (bounded) for Done; lat=-1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_err, output int hold_err);
    logic [31:0] h0, l0;
    h0 = Hi; l0 = Lo;
    lat = -1; busy_err = 0; hold_err = 0;
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (Busy !== 1'b1) busy_err++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) begin
        lat = c;
        if (Busy !== 1'b0) busy_err++;
        break;
      end
      if (Busy !== 1'b1) busy_err++;
      if (Hi !== h0 || Lo !== l0) hold_err++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; Op = 3'b000; A = '0; B = '0; Flush = 1'b0;
    #12;
    total++; if (Hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", Hi); end
    total++; if (Lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", Lo); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_mult();
    int lat, be, he;
    run_op(3'b000, 32'hFFFFFFFE, 32'd3, lat, be, he);
    total++; if (lat !== 32) begin bad++; $display("FAIL mult_latency: got %0d want 32", lat); end
    total++; if (be !== 0) begin bad++; $display("FAIL mult_busy: errors %0d want 0", be); end
    total++; if (he !== 0) begin bad++; $display("FAIL mult_hold: errors %0d want 0", he); end
    total++; if (Hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", Hi); end
    total++; if (Lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo: got %h want fffffffa", Lo); end
    @(posedge Clk); #1;
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse: got %b want 0", Done); end
  endtask

  task automatic test_multu_madd_msub();
    int lat, be, he;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, be, he);
    total++; if (Hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", Hi); end
    total++; if (Lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", Lo); end
    run_op(3'b110, 32'd1, 32'd1, lat, be, he);
    total++; if (lat !== 32) begin bad++; $display("FAIL madd_latency: got %0d want 32", lat); end
    total++; if (Hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL madd_hi: got %h want fffffffe", Hi); end
    total++; if (Lo !== 32'h00000002) begin bad++; $display("FAIL madd_lo: got %h want 00000002", Lo); end
    run_op(3'b111, 32'd1, 32'd2, lat, be, he);
    total++; if (Hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL msub_hi: got %h want fffffffe", Hi); end
    total++; if (Lo !== 32'h00000000) begin bad++; $display("FAIL msub_lo: got %h want 00000000", Lo); end
    run_op(3'b110, 32'hFFFFFFFF, 32'd3, lat, be, he);
    total++; if (Hi !== 32'hFFFFFFFD) begin bad++; $display("FAIL madd_neg_hi: got %h want fffffffd", Hi); end
    total++; if (Lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL madd_neg_lo: got %h want fffffffd", Lo); end
  endtask

  task automatic test_div();
    int lat, be, he;
    run_op(3'b011, 32'd100, 32'd7, lat, be, he);
    total++; if (lat !== 32) begin bad++; $display("FAIL divu_latency: got %0d want 32", lat); end
    total++; if (Lo !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want 0000000e", Lo); end
    total++; if (Hi !== 32'd2) begin bad++; $display("FAIL divu_hi: got %h want 00000002", Hi); end
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, lat, be, he);
    total++; if (Lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo: got %h want fffffffd", Lo); end
    total++; if (Hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi: got %h want ffffffff", Hi); end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, be, he);
    total++; if (Lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", Lo); end
    total++; if (Hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi: got %h want 00000000", Hi); end
    run_op(3'b011, 32'hFFFFFFF9, 32'd2, lat, be, he);
    total++; if (Lo !== 32'h7FFFFFFC) begin bad++; $display("FAIL divu_big_lo: got %h want 7ffffffc", Lo); end
    total++; if (Hi !== 32'd1) begin bad++; $display("FAIL divu_big_hi: got %h want 00000001", Hi); end
  endtask

  task automatic test_div0_mt();
    int lat, be, he;
    run_op(3'b010, 32'd5, 32'd0, lat, be, he);
    total++; if (lat !== 32) begin bad++; $display("FAIL div0_latency: got %0d want 32", lat); end
    total++; if (Lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_lo: got %h want ffffffff", Lo); end
    total++; if (Hi !== 32'd5) begin bad++; $display("FAIL div0_hi: got %h want 00000005", Hi); end
    Start = 1'b1; Op = 3'b100; A = 32'h1234; B = '0;
    @(posedge Clk); #1;
    Start = 1'b0;
    total++; if (Hi !== 32'h1234) begin bad++; $display("FAIL mthi_hi: got %h want 00001234", Hi); end
    total++; if (Lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL mthi_lo_kept: got %h want ffffffff", Lo); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", Busy); end
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL mthi_done: got %b want 1", Done); end
    // Flush with Start while idle must not block the accept.
    Start = 1'b1; Flush = 1'b1; Op = 3'b101; A = 32'hABCD0000;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    total++; if (Lo !== 32'hABCD0000) begin bad++; $display("FAIL mtlo_flush_lo: got %h want abcd0000", Lo); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mtlo_busy: got %b want 0", Busy); end
    @(posedge Clk); #1;
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL mtlo_done_pulse: got %b want 0", Done); end
  endtask

  task automatic test_ignore_and_flush();
    int done_seen, lat;
    logic [31:0] h0, l0;
    // DIVU presented while MULT 6*7 runs must be ignored.
    Start = 1'b1; Op = 3'b000; A = 32'd6; B = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin Start = 1'b1; Op = 3'b011; A = 32'd100; B = 32'd7; end
      if (c == 12) Start = 1'b0;
      @(posedge Clk); #1;
      if (Done === 1'b1) begin lat = c; break; end
    end
    total++; if (lat !== 32) begin bad++; $display("FAIL ignore_latency: got %0d want 32", lat); end
    total++; if (Hi !== 32'd0) begin bad++; $display("FAIL ignore_hi: got %h want 00000000", Hi); end
    total++; if (Lo !== 32'd42) begin bad++; $display("FAIL ignore_lo: got %h want 0000002a", Lo); end
    @(posedge Clk); #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL ignore_no_accept: busy %b want 0", Busy); end
    // Flush on the 10th iteration edge.
    h0 = Hi; l0 = Lo;
    Start = 1'b1; Op = 3'b000; A = 32'd3; B = 32'd5;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge Clk); #1; end
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", Busy); end
    done_seen = 0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL flush_done: pulses %0d want 0", done_seen); end
    total++; if (Hi !== h0 || Lo !== l0) begin bad++; $display("FAIL flush_hilo: got %h_%h want %h_%h", Hi, Lo, h0, l0); end
  endtask

  task automatic test_async_reset();
    int lat, be, he;
    Start = 1'b1; Op = 3'b000; A = 32'd9; B = 32'd9;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    #2;
    Reset_n = 1'b0;
    #1;
    total++; if (Hi !== 32'h0 || Lo !== 32'h0) begin bad++; $display("FAIL areset_hilo: got %h_%h want 0_0", Hi, Lo); end
    total++; if (Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL areset_ctl: busy %b done %b want 0 0", Busy, Done); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    run_op(3'b011, 32'd100, 32'd7, lat, be, he);
    total++; if (lat !== 32 || be !== 0) begin bad++; $display("FAIL areset_next_timing: lat %0d busyerr %0d want 32 0", lat, be); end
    total++; if (Lo !== 32'd14 || Hi !== 32'd2) begin bad++; $display("FAIL areset_next_result: got %h_%h want 00000002_0000000e", Hi, Lo); end
  endtask

  task automatic test_back_to_back();
    int lat, be, he;
    run_op(3'b011, 32'd50, 32'd8, lat, be, he);
    total++; if (Lo !== 32'd6 || Hi !== 32'd2) begin bad++; $display("FAIL b2b_first: got %h_%h want 00000002_00000006", Hi, Lo); end
    // Start is raised in the Done cycle itself.
    run_op(3'b001, 32'd2, 32'd3, lat, be, he);
    total++; if (lat !== 32 || be !== 0) begin bad++; $display("FAIL b2b_timing: lat %0d busyerr %0d want 32 0", lat, be); end
    total++; if (Lo !== 32'd6 || Hi !== 32'd0) begin bad++; $display("FAIL b2b_second: got %h_%h want 00000000_00000006", Hi, Lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_madd_msub();
    test_div();
    test_div0_mt();
    test_ignore_and_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
